// File: rtl/pipelined_adder.sv
// pipelined_adder: parametrised ripple-carry adder split into CHUNK-bit slices,
// one slice per pipeline stage, with the carry handed from stage to stage.
// A valid/ready stream handshake sits on both sides. The whole pipeline
// advances together or holds together, bubbles included.
// Optional build macro: SIGNED_OVF_EN adds a registered two's-complement
// overflow output 'ovf'.

module pipelined_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
`ifdef SIGNED_OVF_EN
   output logic             ovf,
`endif
   output logic             c_out
);

   localparam int STAGES = (WIDTH / CHUNK < 1) ? 1 : WIDTH / CHUNK;

   // Global advance enable: the last stage is free, or it is being drained.
   logic en;

   // Per-stage state. Each stage keeps the full operand words so that the
   // upper, not-yet-added slices (and the sign bits) travel with the data.
   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] carry_q, carry_d;
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];
   logic [WIDTH-1:0]  aOp_q [STAGES];
   logic [WIDTH-1:0]  aOp_d [STAGES];
   logic [WIDTH-1:0]  bOp_q [STAGES];
   logic [WIDTH-1:0]  bOp_d [STAGES];

   // Scratch value for one slice addition, including its carry out.
   logic [CHUNK:0] sliceSum;

`ifdef SIGNED_OVF_EN
   logic ovf_q, ovf_d;
`endif

   // Handshake: in_ready depends only on out_valid and out_ready.
   always_comb begin
      en       = !valid_q[STAGES-1] || out_ready;
      in_ready = en;
   end

   // Next-state for every stage: each adds its own slice to the carry from
   // the stage before and passes the lower sum slices and operands along.
   // Data loads unconditionally on advance, so bubbles carry don't-care data.
   always_comb begin
      sliceSum   = '0;
      valid_d    = '0;
      carry_d    = '0;
      sliceSum   = {1'b0, a[CHUNK-1:0]} + {1'b0, b[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, c_in};
      valid_d[0] = in_valid && in_ready;
      carry_d[0] = sliceSum[CHUNK];
      sum_d[0]   = '0;
      sum_d[0][CHUNK-1:0] = sliceSum[CHUNK-1:0];
      aOp_d[0]   = a;
      bOp_d[0]   = b;
      for (int k = 1; k < STAGES; k++) begin
         sliceSum   = {1'b0, aOp_q[k-1][k*CHUNK +: CHUNK]}
                    + {1'b0, bOp_q[k-1][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, carry_q[k-1]};
         valid_d[k] = valid_q[k-1];
         carry_d[k] = sliceSum[CHUNK];
         sum_d[k]   = sum_q[k-1];
         sum_d[k][k*CHUNK +: CHUNK] = sliceSum[CHUNK-1:0];
         aOp_d[k]   = aOp_q[k-1];
         bOp_d[k]   = bOp_q[k-1];
      end
   end

`ifdef SIGNED_OVF_EN
   // Overflow is formed from the sign bits as they enter the last stage,
   // so it lines up with the final sum.
   always_comb begin
      ovf_d = (aOp_d[STAGES-1][WIDTH-1] == bOp_d[STAGES-1][WIDTH-1])
           && (sum_d[STAGES-1][WIDTH-1] != aOp_d[STAGES-1][WIDTH-1]);
   end
`endif

   // Pipeline registers: clear on reset, advance together when enabled,
   // otherwise every stage (including bubbles) holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         carry_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k] <= '0;
            aOp_q[k] <= '0;
            bOp_q[k] <= '0;
         end
      end else if (en) begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k] <= sum_d[k];
            aOp_q[k] <= aOp_d[k];
            bOp_q[k] <= bOp_d[k];
         end
      end
   end

`ifdef SIGNED_OVF_EN
   // Overflow flag register, advancing in step with the last stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (en) begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

   // The outputs are the last stage's registers, which hold while stalled.
   always_comb begin
      out_valid = valid_q[STAGES-1];
      s         = sum_q[STAGES-1];
      c_out     = carry_q[STAGES-1];
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed scoreboard bench for pipelined_adder.
// The driver pushes each expected result when its operands are accepted. A
// separate monitor pops and compares whenever a result is handed over.

module tb_pipelined_adder;

   localparam int WIDTH  = 16;
   localparam int CHUNK  = 4;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             c_in = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] s;
   logic             c_out;
`ifdef SIGNED_OVF_EN
   logic             ovf;
`endif

   typedef struct packed {
      logic [WIDTH-1:0] s;
      logic             c;
      logic             ovf;
   } exp_t;

   exp_t sbQ[$];
   exp_t e;
   int   totalCnt = 0;
   int   badCnt = 0;

   // Backpressure vectors: a, b, c_in, and hand-computed sum, carry, ovf.
   logic [WIDTH-1:0] bpA [8] = '{16'h0001, 16'h1111, 16'hF000, 16'hABCD,
                                 16'h7FFF, 16'hFFFF, 16'h0F0F, 16'h8001};
   logic [WIDTH-1:0] bpB [8] = '{16'h0002, 16'h2222, 16'h1000, 16'h0000,
                                 16'h7FFF, 16'hFFFF, 16'hF0F0, 16'h8001};
   logic             bpCi [8] = '{0, 0, 0, 1, 0, 1, 0, 0};
   logic [WIDTH-1:0] bpS [8] = '{16'h0003, 16'h3333, 16'h0000, 16'hABCE,
                                 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'h0002};
   logic             bpC [8] = '{0, 0, 1, 0, 0, 1, 0, 1};
   logic             bpO [8] = '{0, 0, 0, 0, 1, 0, 0, 1};

   pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
`ifdef SIGNED_OVF_EN
      .ovf       (ovf),
`endif
      .c_out     (c_out)
   );

   always #5 clk = ~clk;

   // One comparison: counts it, and reports a FAIL line on disagreement.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      totalCnt++;
      if (actual !== required) begin
         badCnt++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
      end
   endtask

   // Present one operand pair until accepted and record its expected result.
   task automatic applyStimulus(input logic [WIDTH-1:0] aV, input logic [WIDTH-1:0] bV,
                                input logic cV, input logic [WIDTH-1:0] eS,
                                input logic eC, input logic eO);
      int  waitCnt = 0;
      bit  done = 0;
      a        = aV;
      b        = bV;
      c_in     = cV;
      in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            sbQ.push_back('{s: eS, c: eC, ovf: eO});
            done = 1;
         end else begin
            waitCnt++;
            if (waitCnt > 50) begin
               checkOutput("acceptTimeout", 0, 1);
               done = 1;
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   // Wait for every expected result to come out, with a cycle budget.
   task automatic drain();
      int n = 0;
      while ((sbQ.size() != 0 || out_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) checkOutput("drainTimeout", 1, 0);
   endtask

   // Monitor: compare each handed-over result with the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpectedOutput", 1, 0);
         end else begin
            e = sbQ.pop_front();
            checkOutput("sum", s, e.s);
            checkOutput("carryOut", c_out, e.c);
`ifdef SIGNED_OVF_EN
            checkOutput("overflow", ovf, e.ovf);
`endif
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("resetOutValid", out_valid, 0);
      checkOutput("resetSum", s, 0);
      checkOutput("resetCarry", c_out, 0);
      checkOutput("resetInReady", in_ready, 1);
`ifdef SIGNED_OVF_EN
      checkOutput("resetOvf", ovf, 0);
`endif
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      $display("[TB] full ripple and latency");
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      in_valid = 1'b0;
      for (int i = 0; i < STAGES; i++) begin
         @(negedge clk);
         checkOutput($sformatf("rippleValid%0d", i), out_valid, (i == STAGES - 1));
         @(posedge clk);
         #1;
      end
      drain();

      $display("[TB] back-to-back");
      applyStimulus(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
      applyStimulus(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      applyStimulus(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);
      in_valid = 1'b0;
      drain();

      $display("[TB] bubbles");
      applyStimulus(16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(16'h3000, 16'h0400, 1'b0, 16'h3400, 1'b0, 1'b0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput($sformatf("bubbleValid%0d", i), out_valid, (i % 2 == 0));
         @(posedge clk);
         #1;
      end
      drain();

      $display("[TB] backpressure");
      fork
         begin
            for (int i = 0; i < 8; i++)
               applyStimulus(bpA[i], bpB[i], bpCi[i], bpS[i], bpC[i], bpO[i]);
            in_valid = 1'b0;
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               checkOutput($sformatf("stallInReady%0d", i), in_ready, 0);
               checkOutput($sformatf("stallValid%0d", i), out_valid, 1);
               checkOutput($sformatf("stallSum%0d", i), s, bpS[1]);
               checkOutput($sformatf("stallCarry%0d", i), c_out, bpC[1]);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("[TB] reset mid-stream");
      applyStimulus(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
      applyStimulus(16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0);
      applyStimulus(16'h0100, 16'h0300, 1'b0, 16'h0400, 1'b0, 1'b0);
      applyStimulus(16'hFFF0, 16'h0020, 1'b0, 16'h0010, 1'b1, 1'b0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("preResetValid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("asyncResetValid", out_valid, 0);
      checkOutput("asyncResetSum", s, 0);
      checkOutput("asyncResetCarry", c_out, 0);
      sbQ.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput($sformatf("postResetIdle%0d", i), out_valid, 0);
         @(posedge clk);
         #1;
      end

      $display("[TB] signed overflow vectors");
      applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      applyStimulus(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      applyStimulus(16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0);
      in_valid = 1'b0;
      drain();

      checkOutput("scoreboardEmpty", sbQ.size(), 0);
      $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined ripple-carry adder. It is the multi-bit, clocked successor to the single-bit full adder cell. Operands are split into CHUNK-bit slices, with one slice added per pipeline stage and the carry passed stage to stage. A valid/ready stream handshake on both sides accepts one operand pair per cycle; datapath blocks use it where a wide add must meet timing.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK, minimum 1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair presented
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A, unsigned (two's complement if SIGNED_OVF_EN)
b  input  WIDTH  operand B
c_in  input  1  carry into bit 0
out_valid  output  1  result presented
out_ready  input  1  downstream accepts result
s  output  WIDTH  sum, a + b + c_in mod 2^WIDTH
c_out  output  1  carry out of bit WIDTH-1

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all stage valid bits, out_valid, s and c_out are 0. in_ready is 1 once reset is released. Internal operand and carry registers clear to 0.
- Transfers: input transfer = in_valid && in_ready. Output transfer = out_valid && out_ready.
- Advance enable: global enable en = !out_valid || out_ready. in_ready = en, which is purely combinational from out_valid/out_ready. When en=1, every stage register loads from its predecessor. When en=0, all stages hold, including bubbles.
- Stage 0: on input transfer, adds a[CHUNK-1:0] + b[CHUNK-1:0] + c_in. It registers the sum slice, the carry, and the untouched upper operand slices.
- Stage k (1..STAGES-1): adds slice k of the delayed operands + carry from stage k-1. It registers the sum slice, carries forward all lower sum slices already computed, and forwards the remaining upper operand slices.
- Bubbles: stage valid bit = previous stage valid bit when en=1. Stage 0 loads in_valid && in_ready. Bubbles propagate as valid=0 with data don't-care, but data registers still load, with no data-dependent gating.
- Latency: exactly STAGES cycles from input transfer to out_valid=1 with no stall; 4 for defaults. Throughput is one result per cycle.
- Output registers: s, c_out and out_valid are the last-stage registers, which are stable while out_valid && !out_ready.
- STAGES=1: degenerates to a single registered adder with the same handshake.
- Stall ordering: results leave in acceptance order. No drop or duplication under any out_ready pattern.
- Simultaneous events: out_ready rising while a new in_valid is present advances everything in the same cycle. This accepts the new pair and retires the old result together.
- Reset mid-operation: all in-flight results are discarded. out_valid goes low asynchronously on the rst_n assertion edge and stays low until new data reaches the last stage.
- Carry rules: carry is full-width ripple. c_out reflects the carry out of the top slice only.

Optional Feature:
- Macro: SIGNED_OVF_EN.
- When defined: adds output port ovf (1 bit, reset 0), registered alongside s. ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]), i.e. two's-complement overflow. Operand sign bits are carried through the pipeline to the last stage to form this.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> out_valid=0, s=0x0000, c_out=0, in_ready=1. Assert rst_n low mid-stream with 3 results in flight -> out_valid=0 immediately, no stale result ever emerges.
- Full ripple: a=0xFFFF, b=0x0001, c_in=0, out_ready=1 -> exactly 4 cycles later out_valid=1, s=0x0000, c_out=1.
- Back-to-back: {0x1234+0x4321, c_in=1}, {0x8000+0x8000, c_in=0}, {0x00FF+0x0F01, c_in=0} on consecutive cycles -> consecutive outputs s=0x5556/c_out=0, 0x0000/1, 0x1000/0.
- Backpressure: stream 8 random pairs, drop out_ready for cycles 5-7 -> in_ready=0 during the stall, s/c_out held stable, all 8 results correct and in order.
- Bubbles: in_valid toggling 1,0,1,0 -> out_valid pattern 1,0,1,0 delayed 4 cycles with correct sums.
- SIGNED_OVF_EN: 0x7FFF+0x0001 -> s=0x8000, ovf=1; 0x8000+0xFFFF -> s=0x7FFF, ovf=1; 0x0001+0xFFFF -> s=0x0000, c_out=1, ovf=0.
